serial_add_unit: RTL and testbench

//  Bit-serial N-bit adder built around a single 1-bit full-adder cell.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/fa_bit.sv | 28 ++
 rtl/serial_add_unit.sv | 127 ++++++++++++
 tb/tb_serial_add_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Types and constants shared by the bit-serial adder and its testbench.
//   state_t   : FSM state encoding (IDLE=0, RUN=1, FIN=2)
//   DEF_WIDTH : default operand width in bits
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage : serial_add_pkg

// File: rtl/fa_bit.sv
// -----------------------------------------------------------------------------
// fa_bit
// Single-bit full adder built from gate primitives.
// Ports:
//   A, B  : addend bits
//   Cin   : carry in
//   S     : sum bit        (A ^ B ^ Cin)
//   Cout  : carry out      (A & B) | ((A ^ B) & Cin)
// -----------------------------------------------------------------------------
module fa_bit (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    logic w_p;  // propagate
    logic w_g;  // generate
    logic w_t;  // carry propagated from Cin

    xor u_xor_p (w_p, A, B);
    xor u_xor_s (S, w_p, Cin);
    and u_and_g (w_g, A, B);
    and u_and_t (w_t, w_p, Cin);
    or  u_or_c  (Cout, w_g, w_t);

endmodule : fa_bit

// File: rtl/serial_add_unit.sv
// -----------------------------------------------------------------------------
// serial_add_unit
// Bit-serial WIDTH-bit adder. Captures A, B and Cin on an accepted start, then
// pushes one bit pair per clock (LSB first) through a single fa_bit cell with
// the carry fed back through a flop. After WIDTH RUN cycles the sum and final
// carry are registered and done pulses for one cycle.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous, active-high reset
//   start : request, sampled only while not busy (IDLE or FIN)
//   A, B  : operands, captured on an accepted start
//   Cin   : carry in, captured on an accepted start
//   busy  : high while the serial addition is running
//   done  : one-cycle pulse, S/Cout valid in this cycle
//   S     : registered sum, held until the next done
//   Cout  : registered carry out, held with S
// -----------------------------------------------------------------------------
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_cout;

    logic w_accept;
    logic w_last;
    logic w_sum;
    logic w_carry;

    // FIN counts as "not busy", so a start held through FIN restarts at once.
    assign w_accept = start && (r_state == IDLE || r_state == FIN);
    assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    fa_bit u_fa (
        .A    (r_sa[0]),
        .B    (r_sb[0]),
        .Cin  (r_c),
        .S    (w_sum),
        .Cout (w_carry)
    );

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the next state gets a default before the case so no path leaves
    // it unassigned; otherwise a latch would be inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = FIN;
            FIN:     w_next_state = start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == FIN);

    // ----------------------------------------------------------- datapath
    // NOTE: every datapath flop is cleared by reset so an add aborted
    // mid-RUN leaves no stale operand, carry or partial sum behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_acc  <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_s    <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            // S/Cout are left alone so the previous result stays visible.
            r_sa  <= A;
            r_sb  <= B;
            r_c   <= Cin;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (r_state == RUN) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            r_c   <= w_carry;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                // Final sum bit goes straight to S; r_acc has not taken it yet.
                r_s    <= {w_sum, r_acc[WIDTH-1:1]};
                r_cout <= w_carry;
            end
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

endmodule : serial_add_unit

// File: tb/tb_serial_add_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_add_unit
// Self-checking bench for serial_add_unit (WIDTH=8). Expected results come from
// plain integer addition of the operands; timing expectations come from the
// WIDTH-cycle latency and one-cycle done pulse.
// -----------------------------------------------------------------------------
module tb_serial_add_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;

    int checks = 0;
    int errors = 0;

    serial_add_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
    );

    always #5 clk = ~clk;

    // Reference model: {Cout,S} is the (W+1)-bit sum of the operands.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start, scramble the inputs after the accept edge, and
    // stop at the cycle done is high (or when the cycle budget runs out).
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output int n_busy, output bit seen_done);
        A = a; B = b; Cin = cin; start = 1'b1;
        tick();
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        n_busy = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (busy) n_busy++;
            tick();
        end
    endtask

    task automatic check_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        int n_busy;
        bit seen;
        logic [W:0] exp;
        exp = ref_sum(a, b, cin);
        do_add(a, b, cin, n_busy, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done: never seen within budget", name);
            return;
        end
        checks++;
        if (n_busy != W) begin
            errors++;
            $display("FAIL %s latency: busy cycles %0d expected %0d", name, n_busy, W);
        end
        checks++;
        if ({Cout, S} !== exp) begin
            errors++;
            $display("FAIL %s result: got Cout=%b S=%h expected Cout=%b S=%h",
                     name, Cout, S, exp[W], exp[W-1:0]);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {Cout, S} !== exp) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b Cout=%b S=%h expected done=0 busy=0 held %h",
                     name, done, busy, Cout, S, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || Cout !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b S=%h Cout=%b expected all zero", busy, done, S, Cout);
        end
        start = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        check_add("add_5a_33", 8'h5A, 8'h33, 1'b0);
        check_add("ripple_ff_01", 8'hFF, 8'h01, 1'b0);
        check_add("cin_ff_00", 8'hFF, 8'h00, 1'b1);
        check_add("zero", 8'h00, 8'h00, 1'b0);
        check_add("max", 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            check_add($sformatf("rand%0d", i), W'($urandom), W'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_ignore_start_in_run();
        int n_busy;
        bit seen;
        A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        A = 8'hFF; B = 8'hFF; Cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen || S !== 8'h30 || Cout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: seen=%b S=%h Cout=%b expected seen=1 S=30 Cout=0", seen, S, Cout);
        end
        n_busy = 0;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done) seen = 1'b1;
            if (busy) n_busy++;
        end
        checks++;
        if (seen || n_busy != 0) begin
            errors++;
            $display("FAIL ignore_start_extra: done seen=%b busy cycles=%0d expected 0 0", seen, n_busy);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        A = 8'hC3; B = 8'h5E; Cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || Cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b S=%h Cout=%b expected all zero", busy, done, S, Cout);
        end
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_run_quiet: activity seen=%b expected 0", seen);
        end
        check_add("after_reset", 8'h7E, 8'h81, 1'b1);
    endtask

    task automatic test_back_to_back();
        bit seen;
        int gap;
        A = 8'h5A; B = 8'h33; Cin = 1'b0; start = 1'b1;
        tick();
        // start stays high; these operands must be ignored during RUN and
        // captured at the FIN edge.
        A = 8'h01; B = 8'h01; Cin = 1'b0;
        gap = 1;
        seen = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) begin seen = 1'b1; break; end
            tick();
            gap++;
        end
        checks++;
        if (!seen || S !== 8'h8D || Cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: seen=%b S=%h Cout=%b expected seen=1 S=8d Cout=0", seen, S, Cout);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || S !== 8'h8D || gap != W + 1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b done=%b S=%h period=%0d expected busy=1 done=0 S=8d period=%0d",
                     busy, done, S, gap, W + 1);
        end
        seen = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            if (done) begin seen = 1'b1; break; end
            checks++;
            if (S !== 8'h8D) begin
                errors++;
                $display("FAIL b2b_hold: S=%h expected 8d while running", S);
            end
            tick();
        end
        checks++;
        if (!seen || S !== 8'h02 || Cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: seen=%b S=%h Cout=%b expected seen=1 S=02 Cout=0", seen, S, Cout);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start_in_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_add_unit
